// File: rtl/seq_pkg.sv
// Shared constants for the recurrence-sequence generator: recurrence select codes
// and FSM state encoding.
package seq_pkg;

  localparam logic [1:0] SEQ_FIB   = 2'b00;
  localparam logic [1:0] SEQ_PELL  = 2'b01;
  localparam logic [1:0] SEQ_JACOB = 2'b10;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/seq_next.sv
// Combinational next-term datapath: f(k+1) from a = f(k-1), b = f(k) for the
// selected second-order recurrence, with a carry flag for any lost upper bits.
module seq_next
  import seq_pkg::*;
#(
  parameter int MSB = 63
) (
  input  logic [MSB:0] a,
  input  logic [MSB:0] b,
  input  logic [1:0]   mode,
  output logic [MSB:0] next,
  output logic         carry
);

  // Two guard bits hold the worst case 3 * (2^W - 1).
  logic [MSB+2:0] a_x;
  logic [MSB+2:0] b_x;
  logic [MSB+2:0] sum;

  assign a_x = {2'b00, a};
  assign b_x = {2'b00, b};

  always_comb begin
    sum = '0;
    case (mode)
      SEQ_PELL:  sum = (b_x << 1) + a_x;
      SEQ_JACOB: sum = b_x + (a_x << 1);
      default:   sum = b_x + a_x;
    endcase
  end

  assign next  = sum[MSB:0];
  assign carry = |sum[MSB+2:MSB+1];

endmodule

// File: rtl/fib_seq_gen.sv
// Recurrence-sequence generator: loads two seeds and streams f(0)..f(n) over a
// valid/ready interface with per-term wrap tagging and a sticky overflow flag.
module fib_seq_gen
  import seq_pkg::*;
#(
  parameter int MSB  = 63,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      mode,
  input  logic [MSB:0]    f0,
  input  logic [MSB:0]    f1,
  input  logic [CNTW-1:0] n,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [MSB:0]    out_data,
  output logic            out_last,
  output logic            out_ovf,
  output logic            busy,
  output logic            done,
  output logic            ovf
);

  state_t          state;
  logic [MSB:0]    a;
  logic [MSB:0]    b;
  logic            a_w;
  logic            b_w;
  logic [CNTW-1:0] idx;
  logic [CNTW-1:0] n_q;
  logic [1:0]      mode_q;
  logic            ovf_q;

  logic [MSB:0]    next;
  logic            carry;
  logic            is_last;

  seq_next #(
    .MSB (MSB)
  ) u_seq_next (
    .a     (a),
    .b     (b),
    .mode  (mode_q),
    .next  (next),
    .carry (carry)
  );

  assign is_last = (idx == n_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      a      <= '0;
      b      <= '0;
      a_w    <= 1'b0;
      b_w    <= 1'b0;
      idx    <= '0;
      n_q    <= '0;
      mode_q <= SEQ_FIB;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a      <= f0;
            b      <= f1;
            a_w    <= 1'b0;
            b_w    <= 1'b0;
            idx    <= '0;
            n_q    <= n;
            mode_q <= mode;
            ovf_q  <= 1'b0;
            state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (out_ready) begin
            ovf_q <= ovf_q | a_w;
            if (is_last) begin
              // Lookahead b is dropped here, so its wrap never reaches ovf.
              state <= ST_DONE;
            end else begin
              a   <= b;
              a_w <= b_w;
              b   <= next;
              b_w <= carry | a_w | b_w;
              idx <= idx + CNTW'(1);
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = (state == ST_RUN);
  assign out_data  = out_valid ? a : '0;
  assign out_last  = out_valid & is_last;
  assign out_ovf   = out_valid & a_w;
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_DONE);
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
// Directed self-checking bench for fib_seq_gen: a 64-bit instance for the
// recurrences and control, an 8-bit instance for wrap/overflow behaviour.
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sel8 = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [63:0] f0 = '0;
  logic [63:0] f1 = '0;
  logic [15:0] n = '0;
  logic        out_ready = 1'b0;

  logic        start64, start8;
  logic        v64, l64, o64, busy64, done64, ovf64;
  logic [63:0] d64;
  logic        v8, l8, o8, busy8, done8, ovf8;
  logic [7:0]  d8;

  logic        obs_valid, obs_last, obs_oflag, obs_busy, obs_done, obs_ovf;
  logic [63:0] obs_data;

  int nchk = 0;
  int nfail = 0;

  assign start64 = start & ~sel8;
  assign start8  = start & sel8;

  fib_seq_gen #(.MSB(63), .CNTW(16)) dut (
    .clk (clk), .rst_n (rst_n), .start (start64), .mode (mode), .f0 (f0), .f1 (f1),
    .n (n), .out_valid (v64), .out_ready (out_ready), .out_data (d64), .out_last (l64),
    .out_ovf (o64), .busy (busy64), .done (done64), .ovf (ovf64)
  );

  fib_seq_gen #(.MSB(7), .CNTW(16)) dut8 (
    .clk (clk), .rst_n (rst_n), .start (start8), .mode (mode), .f0 (f0[7:0]),
    .f1 (f1[7:0]), .n (n), .out_valid (v8), .out_ready (out_ready), .out_data (d8),
    .out_last (l8), .out_ovf (o8), .busy (busy8), .done (done8), .ovf (ovf8)
  );

  always_comb begin
    obs_valid = sel8 ? v8 : v64;
    obs_data  = sel8 ? {56'd0, d8} : d64;
    obs_last  = sel8 ? l8 : l64;
    obs_oflag = sel8 ? o8 : o64;
    obs_busy  = sel8 ? busy8 : busy64;
    obs_done  = sel8 ? done8 : done64;
    obs_ovf   = sel8 ? ovf8 : ovf64;
  end

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Seeds and n are scrambled after the start edge: only the sampled values may matter.
  task automatic launch(input logic [1:0] m, input logic [63:0] a0, input logic [63:0] a1,
                        input logic [15:0] nn);
    mode  = m;
    f0    = a0;
    f1    = a1;
    n     = nn;
    start = 1'b1;
    cyc();
    start = 1'b0;
    mode  = 2'b01;
    f0    = '1;
    f1    = '1;
    n     = 16'd3;
    chkb("valid_after_start", obs_valid, 1'b1);
  endtask

  task automatic stream(input logic [63:0] exp[$], input bit bp, input bit last_ovf,
                        input bit exp_ovf, input bit poke);
    int  i = 0;
    int  budget = 0;
    bit  rdy;
    while (i < exp.size() && budget < 300) begin
      chkb("valid_held", obs_valid, 1'b1);
      if (obs_valid) begin
        chk("data", obs_data, exp[i]);
        chkb("last", obs_last, i == exp.size() - 1);
        chkb("term_ovf", obs_oflag, (i == exp.size() - 1) && last_ovf);
      end
      rdy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
      out_ready = rdy;
      if (poke) start = (budget < 2);
      if (obs_valid && rdy) i++;
      cyc();
      budget++;
    end
    start = 1'b0;
    chk("terms_seen", 64'(i), 64'(exp.size()));
    chkb("done_pulse", obs_done, 1'b1);
    chkb("valid_in_done", obs_valid, 1'b0);
    chkb("busy_in_done", obs_busy, 1'b1);
    chkb("sticky_ovf", obs_ovf, exp_ovf);
    out_ready = 1'b1;
    if (poke) start = 1'b1;
    cyc();
    start = 1'b0;
    chkb("done_cleared", obs_done, 1'b0);
    chkb("idle_busy", obs_busy, 1'b0);
    chkb("idle_valid", obs_valid, 1'b0);
  endtask

  initial begin
    logic [63:0] q[$];

    #1;
    chkb("rst_valid", obs_valid, 1'b0);
    chk("rst_data", obs_data, 64'd0);
    chkb("rst_last", obs_last, 1'b0);
    chkb("rst_term_ovf", obs_oflag, 1'b0);
    chkb("rst_busy", obs_busy, 1'b0);
    chkb("rst_done", obs_done, 1'b0);
    chkb("rst_ovf", obs_ovf, 1'b0);
    cyc();
    cyc();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();

    q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55};
    launch(2'b00, 64'd0, 64'd1, 16'd10);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{0, 1, 2, 5, 12, 29};
    launch(2'b01, 64'd0, 64'd1, 16'd5);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{0, 1, 1, 3, 5, 11};
    launch(2'b10, 64'd0, 64'd1, 16'd5);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{2, 1, 3, 4, 7};
    launch(2'b11, 64'd2, 64'd1, 16'd4);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);

    q = '{0, 1, 1, 2, 3, 5, 8};
    launch(2'b00, 64'd0, 64'd1, 16'd6);
    stream(q, 1'b1, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b1;

    // Start pulses during RUN and DONE must be ignored.
    q = '{0, 1, 1, 2};
    launch(2'b00, 64'd0, 64'd1, 16'd3);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b1);

    q = '{7};
    launch(2'b00, 64'd7, 64'd1, 16'd0);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);

    sel8 = 1'b1;
    q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 121};
    launch(2'b00, 64'd0, 64'd1, 16'd14);
    stream(q, 1'b0, 1'b1, 1'b1, 1'b0);
    chkb("ovf_sticky_idle", obs_ovf, 1'b1);

    q = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233};
    launch(2'b00, 64'd0, 64'd1, 16'd13);
    chkb("ovf_cleared_on_start", obs_ovf, 1'b0);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);
    sel8 = 1'b0;

    // Abort mid-sequence at idx 3 with an asynchronous reset.
    launch(2'b00, 64'd0, 64'd1, 16'd10);
    cyc();
    cyc();
    cyc();
    chk("pre_abort_data", obs_data, 64'd2);
    rst_n = 1'b0;
    #1;
    chkb("abort_valid", obs_valid, 1'b0);
    chkb("abort_busy", obs_busy, 1'b0);
    chkb("abort_done", obs_done, 1'b0);
    chk("abort_data", obs_data, 64'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    q = '{0, 1, 1, 2, 3, 5};
    launch(2'b00, 64'd0, 64'd1, 16'd5);
    stream(q, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/fib_seq_gen.md
# fib_seq_gen

Parametrised recurrence-sequence generator; next generation of the two-register Fibonacci datapath. Loads two seed terms and streams terms f(0)..f(n) of a selectable second-order recurrence (Fibonacci, Pell, Jacobsthal) over a valid/ready interface. Adds start/busy/done control, per-term overflow tagging and backpressure. Sits between the ALU-based compute blocks and any downstream consumer buffer.

## Interface
- MSB, 63, data MSB index; term width W = MSB+1
- CNTW, 16, width of term-index counter and `n`
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  request a new sequence; accepted only in IDLE
- mode  in  2  recurrence select, sampled on accepted start
- f0  in  W  seed term f(0), sampled on accepted start
- f1  in  W  seed term f(1), sampled on accepted start
- n  in  CNTW  index of last term to emit; n+1 terms emitted
- out_valid  out  1  term available
- out_ready  in  1  consumer accepts term
- out_data  out  W  current term f(idx), truncated to W bits
- out_last  out  1  current term is f(n)
- out_ovf  out  1  current term wrapped (directly or via a wrapped operand)
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after last term accepted
- ovf  out  1  sticky: any emitted term of current sequence had out_ovf=1; cleared on accepted start

## Operation
- Recurrence, a = f(k-1), b = f(k): mode 00 Fibonacci f(k+1)=b+a; 01 Pell f(k+1)=2b+a; 10 Jacobsthal f(k+1)=b+2a; 11 reserved, behaves as 00.
- Next term computed at W+2 bits; low W bits kept; carry = any upper bit set.
- Wrap flags travel with registers: a_w, b_w. New b_w = carry | a_w | b_w. Seeds load with flags 0.
- Registers: a (emitted term), b (lookahead term), a_w, b_w, idx (CNTW), n_q, mode_q, state.
- States: IDLE -> RUN on start; RUN -> DONE on handshake with idx==n_q; DONE -> IDLE unconditionally.
- IDLE: out_valid=0; on start: a<=f0, b<=f1, flags<=0, idx<=0, n_q<=n, mode_q<=mode, ovf<=0.
- RUN: out_valid=1, out_data=a, out_ovf=a_w, out_last=(idx==n_q). On handshake, not last: a<=b, a_w<=b_w, b<=next, b_w<=new flag, idx<=idx+1. On any handshake, ovf<=ovf|a_w.
- No handshake: all outputs and registers held stable (AXI-style; valid never drops without handshake).
- DONE: done=1, out_valid=0, busy=1.
- start while busy: ignored, no effect.
- Lookahead term b beyond f(n) never emitted; its wrap never sets ovf.
- n=0: exactly one term f0 with out_last=1.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_ovf=0, busy=0, done=0, ovf=0, state IDLE. rst_n assertion mid-sequence aborts immediately (async); no done.
- start sampled at edge t -> out_valid=1 with f(0) after edge t (cycle t+1).
- Throughput one term/cycle with out_ready held high; sequence of n+1 terms: last handshake at cycle t+1+n, done in cycle t+2+n, IDLE (busy=0) at t+3+n; earliest next start accepted at that edge.
- out_ready may be high before out_valid; no combinational path from out_ready to out_valid.

## Structure
- Shared package seq_pkg: mode constants SEQ_FIB=2'b00, SEQ_PELL=2'b01, SEQ_JACOB=2'b10; state encoding ST_IDLE, ST_RUN, ST_DONE.
- Sub-module seq_next (combinational): inputs a, b, mode; outputs W-bit next and carry. Top holds FSM, registers, handshake.

## Test plan
- Fibonacci, f0=0, f1=1, n=10, out_ready=1 -> out_data 0,1,1,2,3,5,8,13,21,34,55 on consecutive cycles; out_last only on 55; done next cycle; ovf=0.
- Pell n=5 -> 0,1,2,5,12,29; Jacobsthal n=5 -> 0,1,1,3,5,11; mode 11, f0=2, f1=1, n=4 -> 2,1,3,4,7.
- Backpressure: Fibonacci n=6, out_ready pseudo-random (~50%) -> sequence 0,1,1,2,3,5,8 unchanged; out_data/out_last stable while valid&!ready.
- Overflow, MSB=7: Fibonacci 0,1, n=13 -> last 233, ovf=0; n=14 -> last 121 with out_ovf=1, ovf=1; following start clears ovf.
- start pulsed while busy -> ignored, sequence unaffected; n=0, f0=7 -> single term 7 with out_last=1, done next cycle.
- rst_n low during RUN at idx=3 -> out_valid, busy, done 0 immediately; after release, new start runs correctly from f(0).
